// File: rtl/yarvi_uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants.
// Imported by yarvi_uart_tx and the matching receiver.
package yarvi_uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/yarvi_uart_tx.sv
// 8N1 serial transmitter for the console byte stream.
// Ports:
//   clock     - sole clock, rising edge
//   reset     - synchronous, active-high
//   in_valid  - byte offered
//   in_ready  - registered; high in IDLE and in the final stop-bit cycle
//   in_data   - byte to send, captured on in_valid && in_ready
//   txd       - registered serial line, idle/mark = 1
module yarvi_uart_tx
    import yarvi_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       txd
);

    localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] TIMER_TOP  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   LAST_INDEX = IDX_W'(DATA_BITS - 1);

    // Reject bit periods too short for the final-stop-cycle ready lookahead
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("yarvi_uart_tx: CLKS_PER_BIT must be >= 2");
    end

    uart_state_e          state;
    logic [7:0]           shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic [TIMER_W-1:0]   timer;

    wire handshake = in_valid && in_ready;
    wire bit_done  = (timer == '0);

    // Frame sequencer; txd and in_ready are set one edge ahead of the cycle they describe
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            txd      <= 1'b1;
            in_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    in_ready <= 1'b1;
                    if (handshake) begin
                        shreg    <= in_data;
                        timer    <= TIMER_TOP;
                        txd      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        timer   <= TIMER_TOP;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                        state   <= DATA;
                    end else begin
                        timer <= TIMER_W'(timer - 1'b1);
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        timer <= TIMER_TOP;
                        if (bit_idx == LAST_INDEX) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= IDX_W'(bit_idx + 1'b1);
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        timer <= TIMER_W'(timer - 1'b1);
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        // Final stop cycle: ready is high, so a new byte chains with no idle gap
                        if (handshake) begin
                            shreg    <= in_data;
                            timer    <= TIMER_TOP;
                            txd      <= 1'b0;
                            in_ready <= 1'b0;
                            state    <= START;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        timer    <= TIMER_W'(timer - 1'b1);
                        in_ready <= (timer == TIMER_W'(1));
                    end
                end

                default: begin
                    txd      <= 1'b1;
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yarvi_uart_tx.sv
// Self-checking bench for yarvi_uart_tx with CLKS_PER_BIT = 4.
module tb_yarvi_uart_tx;

    localparam int unsigned C = 4;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       txd;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    logic [7:0] exp_q[$];

    yarvi_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .txd      (txd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard producer: every accepted byte is expected on the line
    always @(posedge clock) begin
        if (!reset && in_valid && in_ready)
            exp_q.push_back(in_data);
    end

    // Line monitor: decodes frames mid-bit and checks txd only moves on bit boundaries
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic       mon_prev = 1'b1;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clock) begin
        if (reset) begin
            mon_active = 1'b0;
            exp_q.delete();
        end else if (!mon_active) begin
            if (txd === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_prev   = 1'b0;
                mon_byte   = 8'h00;
            end
        end else begin
            int pos;
            int b;
            mon_cnt++;
            pos = mon_cnt % C;
            b   = mon_cnt / C;
            if (pos != 0)
                chk("mon_bit_boundary", 32'(txd), 32'(mon_prev));
            if (pos == C / 2) begin
                if (b == 0)
                    chk("mon_start_bit", 32'(txd), 32'(1'b0));
                else if (b <= 8)
                    mon_byte[b-1] = txd;
                else
                    chk("mon_stop_bit", 32'(txd), 32'(1'b1));
            end
            mon_prev = txd;
            if (mon_cnt == 10 * C - 1) begin
                mon_active = 1'b0;
                frames_seen++;
                chk("mon_frame_expected", 32'(exp_q.size() != 0), 32'(1'b1));
                if (exp_q.size() != 0)
                    chk("mon_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    // Cycle-by-cycle frame check, entered at cycle T+1 and left at cycle T+10C
    task automatic run_frame(input logic [7:0] b, input bit noisy);
        logic exp_txd;
        for (int n = 1; n <= 10 * int'(C); n++) begin
            if (n <= int'(C))
                exp_txd = 1'b0;
            else if (n <= 9 * int'(C))
                exp_txd = b[(n - int'(C) - 1) / int'(C)];
            else
                exp_txd = 1'b1;
            chk("frame_txd", 32'(txd), 32'(exp_txd));
            chk("frame_ready", 32'(in_ready), 32'(n == 10 * int'(C)));
            if (noisy) begin
                if (n > int'(C) && n <= 9 * int'(C) - 2) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (n < 10 * int'(C))
                tick();
        end
    endtask

    initial begin
        int guard;
        int base_frames;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset release
        repeat (3) begin
            tick();
            chk("reset_txd", 32'(txd), 32'(1'b1));
            chk("reset_ready", 32'(in_ready), 32'(1'b0));
        end
        reset = 1'b0;
        tick();
        chk("release_ready", 32'(in_ready), 32'(1'b1));
        chk("release_txd", 32'(txd), 32'(1'b1));

        // Single byte 0x55
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        run_frame(8'h55, 1'b0);
        tick();
        chk("idle_ready", 32'(in_ready), 32'(1'b1));
        chk("idle_txd", 32'(txd), 32'(1'b1));
        tick();
        chk("idle_ready_hold", 32'(in_ready), 32'(1'b1));

        // Back-to-back 0x00 then 0xFF with in_valid held high
        in_valid = 1'b1;
        in_data  = 8'h00;
        tick();
        in_data = 8'hFF;
        run_frame(8'h00, 1'b0);
        tick();
        in_valid = 1'b0;
        run_frame(8'hFF, 1'b0);
        tick();
        chk("b2b_idle_txd", 32'(txd), 32'(1'b1));

        // Handshake noise mid-frame
        in_valid = 1'b1;
        in_data  = 8'hA3;
        tick();
        in_valid = 1'b0;
        run_frame(8'hA3, 1'b1);
        repeat (5) begin
            tick();
            chk("noise_no_extra_frame", 32'(txd), 32'(1'b1));
        end

        // Reset during data bit 3 of 0x0F
        in_valid = 1'b1;
        in_data  = 8'h0F;
        tick();
        in_valid = 1'b0;
        repeat (4 * C + 1) tick();
        chk("pre_reset_bit3", 32'(txd), 32'(1'b1));
        reset = 1'b1;
        tick();
        chk("midreset_txd", 32'(txd), 32'(1'b1));
        chk("midreset_ready", 32'(in_ready), 32'(1'b0));
        tick();
        reset = 1'b0;
        tick();
        chk("postreset_ready", 32'(in_ready), 32'(1'b1));
        repeat (2 * C) begin
            chk("postreset_idle_txd", 32'(txd), 32'(1'b1));
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h81;
        tick();
        in_valid = 1'b0;
        run_frame(8'h81, 1'b0);
        tick();

        // Random stream with random gaps
        base_frames = frames_seen;
        for (int k = 0; k < 200; k++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            guard = 0;
            while (in_ready !== 1'b1 && guard < 200) begin
                tick();
                guard++;
            end
            chk("rand_handshake_timeout", 32'(guard < 200), 32'(1'b1));
            tick();
        end
        in_valid = 1'b0;
        repeat (12 * C) tick();
        chk("rand_frames_decoded", 32'(frames_seen - base_frames), 32'd200);
        chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
